// File: rtl/bsort_pkg.sv
// Shared definitions for the bubble-sort controller: FSM state encoding,
// default sizing constants and the address-width helper.
package bsort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        WR,
        DONE
    } state_t;

    localparam int DATA_W_DEFAULT   = 16;
    localparam int NUM_ELEM_DEFAULT = 8;

    // Width needed to address n elements; a two-entry bank still needs one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsort_idx_counter.sv
// Pair index (i, i+1) and pass counter for the bubble-sort controller.
// Both addresses are kept as registers so the bank sees glitch-free
// addresses; the end-of-pass and last-pass flags are decoded here.
module bsort_idx_counter
    import bsort_pkg::*;
#(
    parameter int NUM_ELEM = NUM_ELEM_DEFAULT,
    parameter int ADDR_W   = addr_width(NUM_ELEM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic              pass_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic [ADDR_W-1:0] idx_nxt_o,
    output logic [ADDR_W-1:0] pass_o,
    output logic              end_of_pass_o,
    output logic              last_pass_o
);

    localparam int              SUM_W     = ADDR_W + 1;
    localparam logic [SUM_W-1:0] LAST_SUM = SUM_W'(NUM_ELEM - 2);
    localparam logic [ADDR_W-1:0] LAST_P  = ADDR_W'(NUM_ELEM - 2);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_nxt_q;
    logic [ADDR_W-1:0] pass_q;

    // Index/pass update: a new sort or a new pass rewinds to pair (0,1).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            idx_nxt_q <= '0;
            pass_q    <= '0;
        end else if (clr_i) begin
            idx_q     <= '0;
            idx_nxt_q <= ONE;
            pass_q    <= '0;
        end else if (pass_i) begin
            idx_q     <= '0;
            idx_nxt_q <= ONE;
            pass_q    <= pass_q + ONE;
        end else if (step_i) begin
            idx_q     <= idx_nxt_q;
            idx_nxt_q <= idx_nxt_q + ONE;
        end
    end

    // Pass p compares pairs up to i = NUM_ELEM-2-p, i.e. i + p reaches NUM_ELEM-2.
    assign end_of_pass_o = ({1'b0, idx_q} + {1'b0, pass_q}) >= LAST_SUM;
    assign last_pass_o   = (pass_q == LAST_P);

    assign idx_o     = idx_q;
    assign idx_nxt_o = idx_nxt_q;
    assign pass_o    = pass_q;

endmodule

// File: rtl/bsort_ctrl.sv
// Bubble-sort sequencer: walks the register bank pair by pair, compares
// each pair (unsigned, ties never swap) and drives the MUX2X1 select plus
// a one-cycle write strobe to write the pair back swapped.
// Optional build macro BSORT_EARLY_EXIT_EN: finish after the first pass
// that performed no swap instead of always running NUM_ELEM-1 passes.
module bsort_ctrl
    import bsort_pkg::*;
#(
    parameter int data_in_width = DATA_W_DEFAULT,
    parameter int NUM_ELEM      = NUM_ELEM_DEFAULT,
    parameter int ADDR_W        = addr_width(NUM_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [data_in_width-1:0] data_a,
    input  logic [data_in_width-1:0] data_b,
    output logic [ADDR_W-1:0]        addr_a,
    output logic [ADDR_W-1:0]        addr_b,
    output logic                     swap_sel,
    output logic                     wr_en,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        pass_cnt
);

`ifdef BSORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t state_q;
    logic   swap_q;
    logic   wr_en_q;
    logic   busy_q;
    logic   done_q;
    logic   swapped_q;

    logic   end_of_pass;
    logic   last_pass;
    logic   finish;
    logic   a_gt_b;
    logic   cnt_clr;
    logic   cnt_step;
    logic   cnt_pass;

    // Unsigned compare; equal values leave the pair in place (stable sort).
    assign a_gt_b = (data_a > data_b);

    // A pass is clean when neither an earlier pair nor the pair in WR swapped.
    assign finish = last_pass || (EARLY_EXIT && !(swapped_q || swap_q));

    assign cnt_clr  = (state_q == IDLE) && start;
    assign cnt_step = (state_q == WR) && !end_of_pass;
    assign cnt_pass = (state_q == WR) && end_of_pass && !finish;

    bsort_idx_counter #(
        .NUM_ELEM (NUM_ELEM),
        .ADDR_W   (ADDR_W)
    ) u_idx (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (cnt_clr),
        .step_i        (cnt_step),
        .pass_i        (cnt_pass),
        .idx_o         (addr_a),
        .idx_nxt_o     (addr_b),
        .pass_o        (pass_cnt),
        .end_of_pass_o (end_of_pass),
        .last_pass_o   (last_pass)
    );

    // Sequencer with registered outputs set on entry to each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            swap_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            swapped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RD;
                        busy_q    <= 1'b1;
                        swap_q    <= 1'b0;
                        swapped_q <= 1'b0;
                    end
                end
                RD: begin
                    state_q <= CMP;
                end
                CMP: begin
                    swap_q  <= a_gt_b;
                    wr_en_q <= a_gt_b;
                    state_q <= WR;
                end
                WR: begin
                    wr_en_q <= 1'b0;
                    if (!end_of_pass) begin
                        if (swap_q) swapped_q <= 1'b1;
                        state_q <= RD;
                    end else if (finish) begin
                        if (swap_q) swapped_q <= 1'b1;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        swap_q  <= 1'b0;
                    end else begin
                        swapped_q <= 1'b0;
                        state_q   <= RD;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    swap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign swap_sel = swap_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
